// File: rtl/scan_arbiter.sv
// Two-requester scan-chain arbiter: grants one host at a time, shifts its image
// through the chain MSB first, and returns the captured chain contents.
module scan_arbiter #(
  parameter int unsigned CHAIN_LEN = 32,
  parameter int unsigned CNT_W     = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req0_valid,
  input  logic                 req1_valid,
  input  logic [CHAIN_LEN-1:0] req0_data,
  input  logic [CHAIN_LEN-1:0] req1_data,
  output logic                 req0_ready,
  output logic                 req1_ready,
  output logic                 resp_valid,
  output logic [CHAIN_LEN-1:0] resp_data,
  output logic                 resp_id,
  input  logic                 proc_en_req,
  output logic                 proc_en,
  output logic                 scan_enable,
  output logic                 scan_in,
  input  logic                 scan_out,
  output logic                 busy
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [CNT_W-1:0]     r_cnt;
  logic [CNT_W-1:0]     w_cnt_nxt;
  logic [CHAIN_LEN-1:0] r_shreg;
  logic [CHAIN_LEN-1:0] w_shreg_nxt;
  logic [CHAIN_LEN-1:0] w_shifted;
  logic                 r_id;
  logic                 w_id_nxt;
  logic                 r_last;
  logic                 w_last_nxt;
  logic                 r_scan_en;
  logic                 w_scan_en_nxt;
  logic                 r_resp_valid;
  logic                 w_resp_valid_nxt;
  logic [CHAIN_LEN-1:0] r_resp_data;
  logic [CHAIN_LEN-1:0] w_resp_data_nxt;
  logic                 r_resp_id;
  logic                 w_resp_id_nxt;

  logic w_idle;
  logic w_open;
  logic w_grant0;
  logic w_grant1;

  // Round-robin: on contention the requester not served last wins.
  assign w_idle    = (r_state == ST_IDLE);
  assign w_open    = w_idle & ~proc_en_req & ~rst;
  assign w_grant0  = req0_valid & (~req1_valid | r_last);
  assign w_grant1  = req1_valid & (~req0_valid | ~r_last);
  assign w_shifted = {r_shreg[CHAIN_LEN-2:0], scan_out};

  assign req0_ready  = w_open & w_grant0;
  assign req1_ready  = w_open & w_grant1;
  assign proc_en     = proc_en_req & w_idle & ~rst;
  assign busy        = ~w_idle;
  assign scan_enable = r_scan_en;
  assign scan_in     = r_scan_en & r_shreg[CHAIN_LEN-1];
  assign resp_valid  = r_resp_valid;
  assign resp_data   = r_resp_data;
  assign resp_id     = r_resp_id;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_shreg      <= '0;
      r_id         <= 1'b0;
      r_last       <= 1'b1;
      r_scan_en    <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_data  <= '0;
      r_resp_id    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_shreg      <= w_shreg_nxt;
      r_id         <= w_id_nxt;
      r_last       <= w_last_nxt;
      r_scan_en    <= w_scan_en_nxt;
      r_resp_valid <= w_resp_valid_nxt;
      r_resp_data  <= w_resp_data_nxt;
      r_resp_id    <= w_resp_id_nxt;
    end
  end

  // The response is registered on the final shift edge so it is valid throughout DONE.
  always_comb begin
    w_state_nxt      = r_state;
    w_cnt_nxt        = r_cnt;
    w_shreg_nxt      = r_shreg;
    w_id_nxt         = r_id;
    w_last_nxt       = r_last;
    w_scan_en_nxt    = 1'b0;
    w_resp_valid_nxt = 1'b0;
    w_resp_data_nxt  = r_resp_data;
    w_resp_id_nxt    = r_resp_id;
    case (r_state)
      ST_IDLE: begin
        if (req0_ready) begin
          w_state_nxt   = ST_SHIFT;
          w_shreg_nxt   = req0_data;
          w_cnt_nxt     = CNT_W'(CHAIN_LEN - 1);
          w_id_nxt      = 1'b0;
          w_last_nxt    = 1'b0;
          w_scan_en_nxt = 1'b1;
        end else if (req1_ready) begin
          w_state_nxt   = ST_SHIFT;
          w_shreg_nxt   = req1_data;
          w_cnt_nxt     = CNT_W'(CHAIN_LEN - 1);
          w_id_nxt      = 1'b1;
          w_last_nxt    = 1'b1;
          w_scan_en_nxt = 1'b1;
        end
      end
      ST_SHIFT: begin
        w_shreg_nxt = w_shifted;
        if (r_cnt == '0) begin
          w_state_nxt      = ST_DONE;
          w_resp_valid_nxt = 1'b1;
          w_resp_data_nxt  = w_shifted;
          w_resp_id_nxt    = r_id;
        end else begin
          w_cnt_nxt     = r_cnt - CNT_W'(1);
          w_scan_en_nxt = 1'b1;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_scan_arbiter.sv
// Bench for scan_arbiter: a behavioural chain and arbitration model checks
// grants, shifted bits, captured data, latency and processor-enable interlock.
module tb_scan_arbiter;

  localparam int unsigned L = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         req0_valid, req1_valid;
  logic [L-1:0] req0_data, req1_data;
  logic         req0_ready, req1_ready;
  logic         resp_valid;
  logic [L-1:0] resp_data;
  logic         resp_id;
  logic         proc_en_req, proc_en;
  logic         scan_enable, scan_in, scan_out, busy;

  logic [L-1:0] chain = '0;
  logic         load_en = 1'b0;
  logic [L-1:0] load_val = '0;

  int  checks = 0;
  int  errors = 0;
  bit  m_last = 1'b1;
  time t_a, t_b, t_c;

  scan_arbiter #(.CHAIN_LEN(L), .CNT_W(5)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_data(req0_data), .req1_data(req1_data),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_id(resp_id),
    .proc_en_req(proc_en_req), .proc_en(proc_en),
    .scan_enable(scan_enable), .scan_in(scan_in), .scan_out(scan_out),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Scan chain model: shifts toward the MSB, which feeds scan_out.
  always @(posedge clk) begin
    if (load_en) chain <= load_val;
    else if (scan_enable) chain <= {chain[L-2:0], scan_in};
  end
  assign scan_out = chain[L-1];

  task automatic preload(input logic [L-1:0] val);
    req0_valid = 1'b0; req1_valid = 1'b0;
    load_val = val; load_en = 1'b1;
    @(negedge clk);
    load_en = 1'b0;
  endtask

  task automatic do_reset();
    req0_valid = 1'b0; req1_valid = 1'b0; proc_en_req = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_last = 1'b1;
  endtask

  // One full exchange, expected winner and results derived from the model.
  task automatic run_exchange(input bit v0, input bit v1, input logic [L-1:0] d0,
                              input logic [L-1:0] d1, input int pe_at, output time t_resp);
    bit           w;
    bit           done;
    int           sc;
    logic [L-1:0] snap, dacc;
    w    = (v0 && v1) ? !m_last : !v0;
    dacc = w ? d1 : d0;
    snap = chain;
    req0_valid = v0; req1_valid = v1; req0_data = d0; req1_data = d1;
    #1;
    checks++;
    if (req0_ready !== !w || req1_ready !== w) begin
      errors++;
      $display("FAIL grant: ready0=%b ready1=%b, expected winner %0d", req0_ready, req1_ready, w);
    end
    @(posedge clk);
    m_last = w;
    sc = 0; done = 1'b0;
    for (int i = 0; i < int'(L) + 6 && !done; i++) begin
      @(negedge clk);
      if (resp_valid) done = 1'b1;
      else begin
        if (scan_enable) begin
          sc++;
          if (sc <= int'(L)) begin
            checks++;
            if (scan_in !== dacc[L-sc]) begin
              errors++;
              $display("FAIL scan_in bit %0d: got %b, expected %b", sc, scan_in, dacc[L-sc]);
            end
          end
        end
        checks++;
        if (busy !== 1'b1 || proc_en !== 1'b0) begin
          errors++;
          $display("FAIL busy_interlock cycle %0d: busy=%b proc_en=%b, expected 1/0", i, busy, proc_en);
        end
        if (sc == pe_at) proc_en_req = 1'b1;
      end
    end
    t_resp = $time;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL resp_timeout: resp_valid never seen");
    end
    checks++;
    if (sc != int'(L)) begin
      errors++;
      $display("FAIL scan_cycles: got %0d, expected %0d", sc, L);
    end
    checks++;
    if (resp_data !== snap || resp_id !== w || proc_en !== 1'b0) begin
      errors++;
      $display("FAIL resp: data=%h id=%b proc_en=%b, expected %h %b 0", resp_data, resp_id, proc_en, snap, w);
    end
    @(negedge clk);
    checks++;
    if (resp_valid !== 1'b0 || busy !== 1'b0 || scan_enable !== 1'b0 || proc_en !== proc_en_req) begin
      errors++;
      $display("FAIL after_done: resp_valid=%b busy=%b scan_en=%b proc_en=%b", resp_valid, busy, scan_enable, proc_en);
    end
    checks++;
    if (chain !== dacc) begin
      errors++;
      $display("FAIL chain_image: got %h, expected %h", chain, dacc);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; proc_en_req = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1; req0_data = '1; req1_data = '1;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || proc_en !== 1'b0 || req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctl: busy=%b proc_en=%b rdy=%b%b, expected 0", busy, proc_en, req0_ready, req1_ready);
    end
    checks++;
    if (scan_enable !== 1'b0 || scan_in !== 1'b0 || resp_valid !== 1'b0 || resp_data !== '0 || resp_id !== 1'b0) begin
      errors++;
      $display("FAIL reset_out: se=%b si=%b rv=%b rd=%h rid=%b, expected 0", scan_enable, scan_in, resp_valid, resp_data, resp_id);
    end
    do_reset();
  endtask

  task automatic test_basic();
    time t;
    preload(32'hDEADBEEF);
    run_exchange(1'b1, 1'b0, 32'h12345678, 32'h0, -1, t);
  endtask

  task automatic test_proc_hold();
    time t;
    req0_valid = 1'b0; req1_valid = 1'b1; req1_data = 32'hCAFEF00D; proc_en_req = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      checks++;
      if (req1_ready !== 1'b0 || proc_en !== 1'b1 || busy !== 1'b0) begin
        errors++;
        $display("FAIL proc_hold cycle %0d: ready1=%b proc_en=%b busy=%b", i, req1_ready, proc_en, busy);
      end
      @(negedge clk);
    end
    proc_en_req = 1'b0;
    #1;
    checks++;
    if (req1_ready !== 1'b1 || proc_en !== 1'b0) begin
      errors++;
      $display("FAIL proc_release: ready1=%b proc_en=%b, expected 1/0", req1_ready, proc_en);
    end
    run_exchange(1'b0, 1'b1, 32'h0, 32'hCAFEF00D, -1, t);
  endtask

  task automatic test_proc_mid();
    time t;
    preload($urandom);
    run_exchange(1'b1, 1'b0, $urandom, 32'h0, 5, t);
    proc_en_req = 1'b0;
  endtask

  task automatic test_drop();
    time t;
    proc_en_req = 1'b1; req0_valid = 1'b1; req1_valid = 1'b0;
    repeat (3) @(negedge clk);
    req0_valid = 1'b0; proc_en_req = 1'b0;
    #1;
    checks++;
    if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
      errors++;
      $display("FAIL drop_ready: rdy=%b%b, expected 00", req0_ready, req1_ready);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL drop_busy: got %b, expected 0", busy);
    end
    run_exchange(1'b0, 1'b1, 32'h0, $urandom, -1, t);
  endtask

  task automatic test_round_robin();
    time t;
    do_reset();
    for (int i = 0; i < 3; i++) run_exchange(1'b1, 1'b1, $urandom, $urandom, -1, t);
  endtask

  task automatic test_back_to_back();
    logic [L-1:0] d;
    d = $urandom;
    run_exchange(1'b1, 1'b0, d, 32'h0, -1, t_a);
    run_exchange(1'b1, 1'b0, ~d, 32'h0, -1, t_b);
    run_exchange(1'b1, 1'b0, d ^ 32'h5A5A5A5A, 32'h0, -1, t_c);
    checks++;
    if (t_b - t_a != (L + 2) * 10 || t_c - t_b != (L + 2) * 10) begin
      errors++;
      $display("FAIL resp_spacing: got %0t and %0t, expected %0d", t_b - t_a, t_c - t_b, (L + 2) * 10);
    end
  endtask

  task automatic test_random();
    time t;
    bit  v0, v1;
    for (int i = 0; i < 8; i++) begin
      v0 = 1'($urandom % 2);
      v1 = 1'($urandom % 2);
      if (!v0 && !v1) v1 = 1'b1;
      if (($urandom % 2) != 0) preload($urandom);
      run_exchange(v0, v1, $urandom, $urandom, -1, t);
    end
  endtask

  task automatic test_reset_mid();
    time t;
    preload(32'hA5A50F0F);
    req0_valid = 1'b1; req1_valid = 1'b0; req0_data = $urandom;
    @(posedge clk);
    @(negedge clk);
    req0_valid = 1'b0;
    repeat (11) @(negedge clk);
    checks++;
    if (scan_enable !== 1'b1) begin
      errors++;
      $display("FAIL mid_shift: scan_enable=%b, expected 1", scan_enable);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || scan_enable !== 1'b0 || scan_in !== 1'b0 || resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: busy=%b se=%b si=%b rv=%b, expected 0", busy, scan_enable, scan_in, resp_valid);
    end
    @(negedge clk);
    rst = 1'b0;
    m_last = 1'b1;
    for (int i = 0; i < int'(L) + 4; i++) begin
      @(negedge clk);
      checks++;
      if (resp_valid !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL aborted_resp cycle %0d: resp_valid=%b busy=%b", i, resp_valid, busy);
      end
    end
    preload($urandom);
    run_exchange(1'b1, 1'b1, $urandom, $urandom, -1, t);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_proc_hold();
    test_proc_mid();
    test_drop();
    test_round_robin();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
